// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, constants and entry type for the fetch buffer
package fetch_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_ERR   = 2'd2
  } fetch_state_e;

  localparam int PC_INC     = 4;
  localparam int FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush; head is zero when empty
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - multi-outstanding sequential fetcher with in-order buffer; FETCH_MISALIGN_CHK_EN enables misaligned-redirect trap
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int              BITS      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [BITS-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            proc_req,
  output logic            we,
  output logic [BITS-1:0] ADDR_OUT,
  input  logic            mem_rdy,
  input  logic            valid,
  input  logic [BITS-1:0] RDATA,
  output logic            instr_valid,
  output logic [BITS-1:0] INSTR_OUT,
  output logic [BITS-1:0] PC_OUT,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [BITS-1:0] redirect_addr,
  output logic            misalign_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [BITS-1:0] pc;
    logic [BITS-1:0] instr;
  } entry_t;

  fetch_state_e    state;
  logic [BITS-1:0] fetch_pc;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outst_nxt;
  logic [TW-1:0]   tag_count;
  logic [BITS-1:0] tag_pc;
  logic [BITS-1:0] redir_pc;
  entry_t          buf_head;
  logic            accept;
  logic            misalign;
  logic            redir_take;
  logic            rsp_ret;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            tag_full;
  logic            tag_empty;
  logic            buf_full;
  logic            buf_empty;

  assign we       = 1'b0;
  assign ADDR_OUT = fetch_pc;

  // Credit rule: every accepted request already owns a buffer slot.
  assign proc_req = (state == S_FETCH)
                 && (outst < CW'(MAX_OUTST))
                 && (({1'b0, outst} + {1'b0, count}) < (CW + 1)'(DEPTH));
  assign accept   = proc_req && mem_rdy;

`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign = (redirect_addr[1:0] != 2'b00);
  assign redir_pc = redirect_addr;
`else
  assign misalign = 1'b0;
  assign redir_pc = {redirect_addr[BITS-1:2], 2'b00};
`endif

  assign redir_take = (state == S_FETCH) && redirect && !misalign;

  // A response landing in the redirect cycle belongs to the old stream.
  assign rsp_ret   = valid && (outst != '0);
  assign rsp_drop  = rsp_ret && ((drop_cnt != '0) || redir_take);
  assign rsp_keep  = rsp_ret && !rsp_drop;
  assign outst_nxt = outst + CW'(accept) - CW'(rsp_ret);

  fetch_fifo #(
    .WIDTH (BITS),
    .DEPTH (MAX_OUTST)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .flush     (redir_take),
    .head      (tag_pc),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  fetch_fifo #(
    .WIDTH (2 * BITS),
    .DEPTH (DEPTH)
  ) u_instr_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data ({tag_pc, RDATA}),
    .pop       (instr_valid && instr_ready),
    .flush     (redir_take),
    .head      (buf_head),
    .count     (count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign instr_valid = !buf_empty;
  assign INSTR_OUT   = buf_head.instr;
  assign PC_OUT      = buf_head.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop_cnt <= '0;
    end else begin
      outst <= outst_nxt;
      // Requests accepted in the redirect cycle itself are also stale.
      if (redir_take) begin
        drop_cnt <= outst_nxt;
      end else if (valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (redir_take) begin
        fetch_pc <= redir_pc;
      end else if (accept) begin
        fetch_pc <= fetch_pc + BITS'(PC_INC);
      end
      case (state)
        S_INIT:  state <= S_FETCH;
        S_FETCH: if (redirect && misalign) state <= S_ERR;
        default: state <= state;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if ((state == S_FETCH) && redirect && misalign) begin
      misalign_err <= 1'b1;
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{tag_full, tag_empty, tag_count, buf_full};
`else
  assign misalign_err = 1'b0;

  logic unused_sigs;
  assign unused_sigs = ^{tag_full, tag_empty, tag_count, buf_full, redirect_addr[1:0]};
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - randomized scoreboard bench for fetch_buffer against a request-queue model
module tb_fetch_buffer;

  localparam int          BITS      = 32;
  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        proc_req;
  logic        we;
  logic [31:0] ADDR_OUT;
  logic        mem_rdy = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] RDATA = '0;
  logic        instr_valid;
  logic [31:0] INSTR_OUT;
  logic [31:0] PC_OUT;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        misalign_err;

  fetch_buffer #(
    .BITS      (BITS),
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .proc_req      (proc_req),
    .we            (we),
    .ADDR_OUT      (ADDR_OUT),
    .mem_rdy       (mem_rdy),
    .valid         (valid),
    .RDATA         (RDATA),
    .instr_valid   (instr_valid),
    .INSTR_OUT     (INSTR_OUT),
    .PC_OUT        (PC_OUT),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  exp_t        exp_q[$];
  req_t        pend[$];
  logic [31:0] model_pc = RESET_PC;
  int          epoch = 0;
  int          cyc = 0;
  int          since_rst = 0;
  bit          model_err = 0;
  bit          mon_en = 0;
  int          checks = 0;
  int          errors = 0;

  int          k_rdy = 100;
  int          k_ready = 100;
  int          k_redir = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          force_redir = 0;
  logic [31:0] force_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the buffer head must track the model's decode-side queue.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_q.size() != 0});
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got PC_OUT %h want no instruction (cycle %0d)", PC_OUT, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("PC_OUT", PC_OUT, e.pc);
          chk("INSTR_OUT", INSTR_OUT, e.instr);
        end
      end
    end
  end

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst         = 1'b1;
      valid       = 1'b0;
      mem_rdy     = 1'b0;
      redirect    = 1'b0;
      instr_ready = 1'($urandom_range(1));
      if (i >= 1) begin
        chk("rst_proc_req", {31'b0, proc_req}, 32'd0);
        chk("rst_we", {31'b0, we}, 32'd0);
        chk("rst_ADDR_OUT", ADDR_OUT, RESET_PC);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_INSTR_OUT", INSTR_OUT, 32'd0);
        chk("rst_PC_OUT", PC_OUT, 32'd0);
        chk("rst_misalign_err", {31'b0, misalign_err}, 32'd0);
      end
      #6;
      exp_q.delete();
      pend.delete();
      epoch++;
      model_pc  = RESET_PC;
      model_err = 0;
      since_rst = 0;
      cyc++;
    end
    mon_en = 1;
  endtask

  task automatic step();
    bit          acc;
    bit          rsp;
    bit          rtake;
    req_t        r;
    logic [31:0] ra;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("proc_req", {31'b0, proc_req},
        {31'b0, (since_rst >= 1) && !model_err && (pend.size() < MAX_OUTST)
                && (pend.size() + exp_q.size() < DEPTH)});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, model_err});
    mem_rdy = ($urandom_range(99) < k_rdy);
    rsp = 0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      r     = pend.pop_front();
      rsp   = 1;
      valid = 1'b1;
      RDATA = mem_word(r.addr);
    end else begin
      // A response with nothing outstanding (just out of reset) must be ignored.
      valid = (since_rst == 0);
      RDATA = $urandom;
    end
    acc = proc_req && mem_rdy;
    if (acc) begin
      chk("ADDR_OUT", ADDR_OUT, model_pc);
      pend.push_back('{addr: model_pc, epoch: epoch,
                       due: cyc + int'($urandom_range(lat_max, lat_min))});
      model_pc = model_pc + 32'd4;
    end
    instr_ready = ($urandom_range(99) < k_ready);
    ra = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
    if (force_redir) ra = force_addr;
    redirect = force_redir || ($urandom_range(99) < k_redir)
            || ((k_redir > 0) && rsp && acc && ($urandom_range(1) == 1));
    redirect_addr = redirect ? ra : $urandom;
    rtake = redirect && (since_rst >= 1) && !model_err;
    #6;
`ifdef FETCH_MISALIGN_CHK_EN
    if (rtake && ra[1:0] != 2'b00) begin
      model_err = 1;
      rtake     = 0;
    end
`endif
    if (rsp && !rtake && r.epoch == epoch) begin
      exp_q.push_back('{pc: r.addr, instr: mem_word(r.addr)});
    end
    if (rtake) begin
      exp_q.delete();
      epoch++;
      model_pc = {ra[31:2], 2'b00};
    end
    cyc++;
    since_rst++;
  endtask

  initial begin
    do_reset(3);

    // Streaming: full rate, 1-cycle memory, decode always ready.
    k_rdy = 100; k_ready = 100; k_redir = 0; lat_min = 1; lat_max = 1;
    repeat (30) step();

    // Decode stalled: buffer fills, then a single pop frees one slot.
    k_ready = 0;
    repeat (10) step();
    k_ready = 100;
    step();
    k_ready = 0;
    repeat (6) step();
    k_ready = 100;
    repeat (8) step();

    // Redirect with requests in flight.
    lat_min = 3; lat_max = 3;
    repeat (6) step();
    force_redir = 1; force_addr = 32'h0000_0100;
    step();
    force_redir = 0;
    repeat (12) step();

    // Randomized traffic with redirects, biased toward accept+response collisions.
    k_rdy = 70; k_ready = 60; k_redir = 8; lat_min = 1; lat_max = 3;
    repeat (300) step();

    // Address wrap near the top of the address space.
    k_redir = 0; k_rdy = 50; k_ready = 80; lat_min = 3; lat_max = 3;
    force_redir = 1; force_addr = 32'hFFFF_FFF0;
    step();
    force_redir = 0;
    repeat (40) step();

    // Misaligned redirect target.
    k_rdy = 100; k_ready = 100; lat_min = 1; lat_max = 2;
    force_redir = 1; force_addr = 32'h0000_0102;
    step();
    force_redir = 0;
    repeat (15) step();

    // Reset in the middle of traffic.
    lat_min = 2; lat_max = 2;
    repeat (5) step();
    do_reset(2);
    k_rdy = 80; k_ready = 70; k_redir = 5; lat_min = 1; lat_max = 3;
    repeat (40) step();

    // Drain everything outstanding.
    k_rdy = 0; k_ready = 100; k_redir = 0;
    repeat (12) step();
    @(posedge clk);
    #1;
    chk("drain_instr_valid", {31'b0, instr_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
